rv_ctl: RTL and testbench

- Multicycle control FSM for the simple RISC-V core.
- Consumes instr/zero from the datapath. Drives every datapath enable and mux select, plus the data-memory write strobe.
- One instruction in flight at a time. Purely Moore-decoded outputs, except conditional pcwrite in BRANCH.

---
 rtl/rv_ctl.sv | 180 ++++++++++++++++++
 tb/tb_rv_ctl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_ctl.sv
// Multicycle control FSM for the simple RISC-V core; Moore outputs except the BRANCH pcwrite.
// Optional RV_CTL_ILLEGAL_EN: unsupported instructions halt the core and raise illegal.
module rv_ctl #(
  parameter int DPWIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DPWIDTH-1:0] instr,
  input  logic               zero,
  output logic               pcsourse,
  output logic               pcwrite,
  output logic               pccen,
  output logic               irwrite,
  output logic               addrwrite,
  output logic [1:0]         wbsel,
  output logic               regwen,
  output logic [1:0]         immsel,
  output logic [1:0]         asel,
  output logic               bsel,
  output logic [3:0]         alusel,
  output logic               sw_sel,
  output logic               mdrwrite,
`ifdef RV_CTL_ILLEGAL_EN
  output logic               dmem_wen,
  output logic               illegal
`else
  output logic               dmem_wen
`endif
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALUWB, S_MEMADDR, S_ADDRLATCH,
    S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH, S_JAL, S_HALT
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  state_t state_q, state_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       unused_instr_bits;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7_5 = instr[30];
  assign unused_instr_bits = ^{instr[DPWIDTH-1:31], instr[29:15], instr[11:7]};

  // alt selects SUB/SRA; immediate forms pass alt=0 so ADDI never becomes SUB.
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_op = alt ? 4'd1 : 4'd0;
      3'b001:  alu_op = 4'd2;
      3'b010:  alu_op = 4'd3;
      3'b011:  alu_op = 4'd4;
      3'b100:  alu_op = 4'd5;
      3'b101:  alu_op = alt ? 4'd7 : 4'd6;
      3'b110:  alu_op = 4'd8;
      default: alu_op = 4'd9;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    pcsourse  = 1'b0;
    pcwrite   = 1'b0;
    pccen     = 1'b0;
    irwrite   = 1'b0;
    addrwrite = 1'b0;
    wbsel     = 2'd0;
    regwen    = 1'b0;
    immsel    = 2'd0;
    asel      = 2'd0;
    bsel      = 1'b0;
    alusel    = 4'd0;
    sw_sel    = 1'b0;
    mdrwrite  = 1'b0;
    dmem_wen  = 1'b0;
`ifdef RV_CTL_ILLEGAL_EN
    illegal   = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        irwrite = 1'b1;
        pccen   = 1'b1;
        pcwrite = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        asel   = 2'd2;
        bsel   = 1'b1;
        immsel = (opcode == OP_JAL) ? 2'd0 : 2'd1;
`ifdef RV_CTL_ILLEGAL_EN
        state_d = S_HALT;
`else
        state_d = S_FETCH;
`endif
        case (opcode)
          OP_R:     state_d = S_EXEC_R;
          OP_I:     if (!(funct3 == 3'b101 && funct7_5)) state_d = S_EXEC_I;
          OP_LOAD,
          OP_STORE: if (funct3 == 3'b010) state_d = S_MEMADDR;
          OP_BR:    if (funct3 == 3'b000 || funct3 == 3'b001) state_d = S_BRANCH;
          OP_JAL:   state_d = S_JAL;
          default:  ;
        endcase
      end
      S_EXEC_R: begin
        alusel  = alu_op(funct3, funct7_5);
        state_d = S_ALUWB;
      end
      S_EXEC_I: begin
        bsel    = 1'b1;
        immsel  = 2'd3;
        alusel  = alu_op(funct3, 1'b0);
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        wbsel   = 2'd1;
        regwen  = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMADDR: begin
        bsel    = 1'b1;
        immsel  = (opcode == OP_STORE) ? 2'd2 : 2'd3;
        state_d = S_ADDRLATCH;
      end
      S_ADDRLATCH: begin
        addrwrite = 1'b1;
        state_d   = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mdrwrite = 1'b1;
        state_d  = S_MEMWB;
      end
      S_MEMWB: begin
        regwen  = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWR: begin
        dmem_wen = 1'b1;
        sw_sel   = 1'b1;
        state_d  = S_FETCH;
      end
      // aluout still carries the DECODE-computed target while the ALU compares rs1/rs2.
      S_BRANCH: begin
        alusel   = 4'd1;
        pcsourse = 1'b1;
        pcwrite  = (funct3 == 3'b000 && zero) || (funct3 == 3'b001 && !zero);
        state_d  = S_FETCH;
      end
      S_JAL: begin
        wbsel    = 2'd2;
        regwen   = 1'b1;
        pcwrite  = 1'b1;
        pcsourse = 1'b1;
        state_d  = S_FETCH;
      end
`ifdef RV_CTL_ILLEGAL_EN
      S_HALT: begin
        illegal = 1'b1;
        state_d = S_HALT;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_rv_ctl.sv
// Directed bench for rv_ctl: stimulus queues per-cycle expected outputs, a negedge monitor pops and compares.
module tb_rv_ctl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        zero = 1'b0;
  logic        pcsourse, pcwrite, pccen, irwrite, addrwrite, regwen, bsel, sw_sel, mdrwrite, dmem_wen;
  logic [1:0]  wbsel, immsel, asel;
  logic [3:0]  alusel;
`ifdef RV_CTL_ILLEGAL_EN
  logic        illegal;
`endif

  typedef struct packed {
    logic       pcsourse;
    logic       pcwrite;
    logic       pccen;
    logic       irwrite;
    logic       addrwrite;
    logic [1:0] wbsel;
    logic       regwen;
    logic [1:0] immsel;
    logic [1:0] asel;
    logic       bsel;
    logic [3:0] alusel;
    logic       sw_sel;
    logic       mdrwrite;
    logic       dmem_wen;
`ifdef RV_CTL_ILLEGAL_EN
    logic       illegal;
`endif
  } out_t;

  out_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    failures = 0;

  rv_ctl #(.DPWIDTH(32)) dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero),
    .pcsourse(pcsourse), .pcwrite(pcwrite), .pccen(pccen), .irwrite(irwrite),
    .addrwrite(addrwrite), .wbsel(wbsel), .regwen(regwen), .immsel(immsel),
    .asel(asel), .bsel(bsel), .alusel(alusel), .sw_sel(sw_sel),
    .mdrwrite(mdrwrite),
`ifdef RV_CTL_ILLEGAL_EN
    .dmem_wen(dmem_wen),
    .illegal(illegal)
`else
    .dmem_wen(dmem_wen)
`endif
  );

  always #5 clk = ~clk;

  // Hand-written expected output vector for each controller step.
  function automatic out_t v_fetch();
    out_t o = '0; o.irwrite = 1; o.pccen = 1; o.pcwrite = 1; return o;
  endfunction
  function automatic out_t v_decode(input logic is_jal);
    out_t o = '0; o.asel = 2'd2; o.bsel = 1; o.immsel = is_jal ? 2'd0 : 2'd1; return o;
  endfunction
  function automatic out_t v_exec_r(input logic [3:0] op);
    out_t o = '0; o.alusel = op; return o;
  endfunction
  function automatic out_t v_exec_i(input logic [3:0] op);
    out_t o = '0; o.bsel = 1; o.immsel = 2'd3; o.alusel = op; return o;
  endfunction
  function automatic out_t v_aluwb();
    out_t o = '0; o.wbsel = 2'd1; o.regwen = 1; return o;
  endfunction
  function automatic out_t v_memaddr(input logic is_store);
    out_t o = '0; o.bsel = 1; o.immsel = is_store ? 2'd2 : 2'd3; return o;
  endfunction
  function automatic out_t v_addrlatch();
    out_t o = '0; o.addrwrite = 1; return o;
  endfunction
  function automatic out_t v_memrd();
    out_t o = '0; o.mdrwrite = 1; return o;
  endfunction
  function automatic out_t v_memwb();
    out_t o = '0; o.regwen = 1; return o;
  endfunction
  function automatic out_t v_memwr();
    out_t o = '0; o.dmem_wen = 1; o.sw_sel = 1; return o;
  endfunction
  function automatic out_t v_branch(input logic taken);
    out_t o = '0; o.alusel = 4'd1; o.pcsourse = 1; o.pcwrite = taken; return o;
  endfunction
  function automatic out_t v_jal();
    out_t o = '0; o.wbsel = 2'd2; o.regwen = 1; o.pcwrite = 1; o.pcsourse = 1; return o;
  endfunction
`ifdef RV_CTL_ILLEGAL_EN
  function automatic out_t v_halt();
    out_t o = '0; o.illegal = 1; return o;
  endfunction
`endif

  function automatic out_t sample();
    out_t o;
    o.pcsourse = pcsourse; o.pcwrite = pcwrite; o.pccen = pccen; o.irwrite = irwrite;
    o.addrwrite = addrwrite; o.wbsel = wbsel; o.regwen = regwen; o.immsel = immsel;
    o.asel = asel; o.bsel = bsel; o.alusel = alusel; o.sw_sel = sw_sel;
    o.mdrwrite = mdrwrite; o.dmem_wen = dmem_wen;
`ifdef RV_CTL_ILLEGAL_EN
    o.illegal = illegal;
`endif
    return o;
  endfunction

  // Monitor: one expected vector per falling edge while anything is queued.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      out_t  e;
      out_t  a;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = sample();
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s: got %h expected %h", n, a, e);
      end
    end
  end

  task automatic expect_v(input out_t o, input string n);
    exp_q.push_back(o);
    name_q.push_back(n);
  endtask

  // Async reset pulse between edges; the FETCH check lands while rst is still high.
  task automatic start(input logic [31:0] i, input logic z, input string n);
    @(posedge clk);
    #2 rst = 1'b1;
    instr = i;
    zero = z;
    expect_v(v_fetch(), {n, "_rst"});
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic drain(input string n);
    int cyc = 0;
    while (exp_q.size() > 0 && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: %0d vectors pending, required 0", n, exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  task automatic run_alu(input logic [31:0] i, input logic is_r, input logic [3:0] op, input string n);
    start(i, 1'b0, n);
    expect_v(v_fetch(), {n, "_c1"});
    expect_v(v_decode(1'b0), {n, "_c2"});
    expect_v(is_r ? v_exec_r(op) : v_exec_i(op), {n, "_c3"});
    expect_v(v_aluwb(), {n, "_c4"});
    expect_v(v_fetch(), {n, "_next"});
    drain(n);
  endtask

  task automatic run_branch(input logic [31:0] i, input logic z, input logic taken, input string n);
    start(i, z, n);
    expect_v(v_fetch(), {n, "_c1"});
    expect_v(v_decode(1'b0), {n, "_c2"});
    expect_v(v_branch(taken), {n, "_c3"});
    expect_v(v_fetch(), {n, "_next"});
    drain(n);
  endtask

  task automatic run_bad(input logic [31:0] i, input string n);
    start(i, 1'b0, n);
    expect_v(v_fetch(), {n, "_c1"});
    expect_v(v_decode(1'b0), {n, "_c2"});
`ifdef RV_CTL_ILLEGAL_EN
    expect_v(v_halt(), {n, "_halt1"});
    expect_v(v_halt(), {n, "_halt2"});
    expect_v(v_halt(), {n, "_halt3"});
`else
    expect_v(v_fetch(), {n, "_c3"});
    expect_v(v_decode(1'b0), {n, "_c4"});
    expect_v(v_fetch(), {n, "_c5"});
`endif
    drain(n);
  endtask

  task automatic run_lw(input string n);
    start(32'h00802203, 1'b0, n);
    expect_v(v_fetch(), {n, "_c1"});
    expect_v(v_decode(1'b0), {n, "_c2"});
    expect_v(v_memaddr(1'b0), {n, "_c3"});
    expect_v(v_addrlatch(), {n, "_c4"});
    expect_v(v_memrd(), {n, "_c5"});
    expect_v(v_memwb(), {n, "_c6"});
    expect_v(v_fetch(), {n, "_next"});
    drain(n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    run_alu(32'h00500093, 1'b0, 4'd0, "addi");
    run_alu(32'h402081B3, 1'b1, 4'd1, "sub");
    run_alu(32'h4020D1B3, 1'b1, 4'd7, "sra");
    run_alu(32'h0FF0F093, 1'b0, 4'd9, "andi");
    run_lw("lw");

    start(32'h00102223, 1'b0, "sw");
    expect_v(v_fetch(), "sw_c1");
    expect_v(v_decode(1'b0), "sw_c2");
    expect_v(v_memaddr(1'b1), "sw_c3");
    expect_v(v_addrlatch(), "sw_c4");
    expect_v(v_memwr(), "sw_c5");
    expect_v(v_fetch(), "sw_next");
    drain("sw");

    run_branch(32'h00000463, 1'b1, 1'b1, "beq_z1");
    run_branch(32'h00000463, 1'b0, 1'b0, "beq_z0");
    run_branch(32'h00001463, 1'b0, 1'b1, "bne_z0");
    run_branch(32'h00001463, 1'b1, 1'b0, "bne_z1");

    start(32'h0080006F, 1'b0, "jal");
    expect_v(v_fetch(), "jal_c1");
    expect_v(v_decode(1'b1), "jal_c2");
    expect_v(v_jal(), "jal_c3");
    expect_v(v_fetch(), "jal_next");
    drain("jal");

    run_bad(32'hFFFFFFFF, "ill_ff");
    run_bad(32'h4010D093, "ill_srai");
    run_bad(32'h00800203, "ill_lb");

    // Reset lands mid-load (after MEMADDR); the restarted load must run cleanly.
    start(32'h00802203, 1'b0, "lw_part");
    expect_v(v_fetch(), "lw_part_c1");
    expect_v(v_decode(1'b0), "lw_part_c2");
    expect_v(v_memaddr(1'b0), "lw_part_c3");
    drain("lw_part");
    run_lw("lw_midrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
